// File: rtl/resistor_capacitor_low_pass_filter.sv
// rtl/resistor_capacitor_low_pass_filter.sv - first-order RC low-pass filter, oversampled fixed-point integrator
module resistor_capacitor_low_pass_filter #(
  parameter int CLOCK_RATE   = 50000000,
  parameter int SAMPLE_RATE  = 48000,
  parameter int R            = 47000,
  parameter int C_35_SHIFTED = 1615,
  parameter int OVERSAMPLE   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        audio_clk_en,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun
);

  // Filter coefficient: alpha = dt / (RC + dt), in Q16. dt and RC are both
  // scaled by 2^32 so the ratio is unit-free.
  localparam logic [63:0] DELTA_T_32 = (64'd1 << 32) / (64'(SAMPLE_RATE) * 64'(OVERSAMPLE));
  localparam logic [63:0] RC_32      = (64'(R) * 64'(C_35_SHIFTED)) >> 3;
  localparam logic [63:0] ALPHA_64   = (DELTA_T_32 << 16) / (RC_32 + DELTA_T_32);
  // alpha < 1.0, so the Q16 value always fits below 2^16 and is positive here.
  localparam logic signed [16:0] ALPHA_16 = 17'(ALPHA_64);

  // A full integration must complete before the next audio strobe can arrive.
  if (OVERSAMPLE < 1 || OVERSAMPLE > 64) begin : g_bad_oversample
    $error("OVERSAMPLE must be in 1..64");
  end
  if (2 * OVERSAMPLE + 2 > CLOCK_RATE / SAMPLE_RATE) begin : g_bad_rate
    $error("integration does not fit within one audio sample period");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIFF = 2'd1,
    MAC  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic signed [15:0] x_q, x_d;
  logic signed [15:0] y_q, y_d;
  logic signed [16:0] diff_q, diff_d;
  logic [6:0]         cnt_q, cnt_d;
  logic [15:0]        out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;

  logic signed [33:0] diff_ext;
  logic signed [33:0] alpha_ext;
  logic signed [33:0] prod;
  logic signed [33:0] y_ext;
  logic signed [33:0] sum_w;
  logic signed [15:0] sum_sat;

  // One Euler step: y + floor(diff * alpha / 2^16), clamped to the 16-bit range.
  always_comb begin
    diff_ext  = 34'(diff_q);
    alpha_ext = 34'(ALPHA_16);
    prod      = diff_ext * alpha_ext;
    y_ext     = 34'(y_q);
    sum_w     = y_ext + (prod >>> 16);
    if (sum_w > 34'sd32767) begin
      sum_sat = 16'sh7fff;
    end else if (sum_w < -34'sd32768) begin
      sum_sat = -16'sh8000;
    end else begin
      sum_sat = sum_w[15:0];
    end
  end

  // Next-state and datapath updates for the integration sequencer.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    diff_d      = diff_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    // Any strobe outside IDLE (including the OUT cycle) is dropped and flagged.
    overrun_d   = audio_clk_en && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (audio_clk_en) begin
          x_d     = in;
          cnt_d   = 7'd0;
          state_d = DIFF;
        end
      end
      DIFF: begin
        diff_d  = 17'(x_q) - 17'(y_q);
        state_d = MAC;
      end
      MAC: begin
        y_d   = sum_sat;
        cnt_d = cnt_q + 7'd1;
        if (cnt_d < 7'(OVERSAMPLE)) begin
          state_d = DIFF;
        end else begin
          state_d = OUT;
        end
      end
      OUT: begin
        out_d       = y_q;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any sample in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      diff_q      <= diff_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule
